unsigned_multiplier_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit unsigned combinational array multiplier between NUM_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the multiplier's enable and operand inputs. It holds enable for a fixed settle window, then registers the product and returns it with the requester ID over a valid/ready response channel. It sits between client blocks and the shared multiplier instance.

---
 rtl/unsigned_multiplier_arbiter_pkg.sv | 20 ++
 rtl/round_robin_arbiter.sv | 39 +++
 rtl/unsigned_multiplier_arbiter.sv | 124 ++++++++++++
 tb/tb_unsigned_multiplier_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_multiplier_arbiter_pkg.sv
// Shared types and defaults for the multiplier arbiter/sequencer.
package unsigned_multiplier_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned DefaultNumReq       = 4;
    localparam int unsigned DefaultDataWidth    = 16;
    localparam int unsigned DefaultSettleCycles = 2;
    // Wide enough for the largest settle window (15).
    localparam int unsigned SettleCntWidth      = 4;

    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// One-hot round-robin grant; the search starts one past the pointer and wraps.
module round_robin_arbiter
    import unsigned_multiplier_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefaultNumReq,
    localparam int unsigned IdW    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdW-1:0]     ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdW-1:0]     idx_o
);

    int unsigned    cand;
    logic [IdW-1:0] cand_idx;
    logic           found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IdW'(cand);
            if (en_i && !found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/unsigned_multiplier_arbiter.sv
// Shares one combinational multiplier between NUM_REQ requesters: grant, settle, respond.
module unsigned_multiplier_arbiter
    import unsigned_multiplier_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DefaultNumReq,
    parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
    parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles,
    localparam int unsigned IdW          = id_width(NUM_REQ),
    localparam int unsigned ProdW        = 2 * DATA_WIDTH
) (
    input  logic                          Clock_In,
    input  logic                          Reset_n_In,
    input  logic [NUM_REQ-1:0]            Req_Valid_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_A_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_B_In,
    output logic [NUM_REQ-1:0]            Req_Ready_Out,
    output logic                          Resp_Valid_Out,
    input  logic                          Resp_Ready_In,
    output logic [ProdW-1:0]              Resp_Data_Out,
    output logic [IdW-1:0]                Resp_Id_Out,
    output logic                          Busy_Out,
    output logic                          Mult_Enable_Out,
    output logic [DATA_WIDTH-1:0]         Mult_Data_A_Out,
    output logic [DATA_WIDTH-1:0]         Mult_Data_B_Out,
    input  logic [ProdW-1:0]              Mult_Result_In
);

    state_e                    state_q, state_d;
    logic [IdW-1:0]            ptr_q, ptr_d;
    logic [IdW-1:0]            id_q, id_d;
    logic [SettleCntWidth-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     a_q, a_d;
    logic [DATA_WIDTH-1:0]     b_q, b_d;
    logic [ProdW-1:0]          prod_q, prod_d;

    logic                      arb_en;
    logic [NUM_REQ-1:0]        gnt;
    logic [IdW-1:0]            gnt_idx;
    logic                      xfer;
    logic [DATA_WIDTH-1:0]     sel_a, sel_b;

    // Reset also masks the grant so every output reads zero while reset is held.
    assign arb_en = (state_q == StIdle) && Reset_n_In;

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i (Req_Valid_In),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign xfer  = |(gnt & Req_Valid_In);
    assign sel_a = Req_Data_A_In[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign sel_b = Req_Data_B_In[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    cnt_d   = SettleCntWidth'(SETTLE_CYCLES - 1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SettleCntWidth'(1);
                end else begin
                    prod_d  = Mult_Result_In;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (Resp_Ready_In) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q <= StIdle;
            ptr_q   <= IdW'(NUM_REQ - 1);
            id_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign Req_Ready_Out   = gnt;
    assign Resp_Valid_Out  = (state_q == StResp);
    assign Resp_Data_Out   = prod_q;
    assign Resp_Id_Out     = id_q;
    assign Busy_Out        = (state_q != StIdle);
    assign Mult_Enable_Out = (state_q == StExec);
    assign Mult_Data_A_Out = a_q;
    assign Mult_Data_B_Out = b_q;

endmodule

// File: tb/tb_unsigned_multiplier_arbiter.sv
// Scoreboard bench for unsigned_multiplier_arbiter with a behavioural shared multiplier.
module tb_unsigned_multiplier_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] a_bus, b_bus;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_id;
    logic        busy;
    logic        mult_en;
    logic [15:0] mult_a, mult_b;
    wire  [31:0] mult_res;

    logic [15:0] a_drv [4];
    logic [15:0] b_drv [4];

    rec_t sb[$];
    rec_t rsp_got[$];
    int   gnt_ids[$];
    int   gnt_cyc[$];
    int   cyc;
    bit   resp_seen;
    int   n_vec;
    int   n_err;

    unsigned_multiplier_arbiter #(
        .NUM_REQ       (4),
        .DATA_WIDTH    (16),
        .SETTLE_CYCLES (2)
    ) dut (
        .Clock_In        (clk),
        .Reset_n_In      (rst_n),
        .Req_Valid_In    (req_valid),
        .Req_Data_A_In   (a_bus),
        .Req_Data_B_In   (b_bus),
        .Req_Ready_Out   (req_ready),
        .Resp_Valid_Out  (resp_valid),
        .Resp_Ready_In   (resp_ready),
        .Resp_Data_Out   (resp_data),
        .Resp_Id_Out     (resp_id),
        .Busy_Out        (busy),
        .Mult_Enable_Out (mult_en),
        .Mult_Data_A_Out (mult_a),
        .Mult_Data_B_Out (mult_b),
        .Mult_Result_In  (mult_res)
    );

    // Shared multiplier: floats when disabled.
    assign mult_res = mult_en ? (32'(mult_a) * 32'(mult_b)) : 32'bz;

    always_comb begin
        a_bus = '0;
        b_bus = '0;
        for (int i = 0; i < 4; i++) begin
            a_bus[i*16 +: 16] = a_drv[i];
            b_bus[i*16 +: 16] = b_drv[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle: record grants/responses at negedge, return 1 time unit after posedge.
    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    sb.push_back({2'(i), 32'(a_drv[i]) * 32'(b_drv[i])});
                    gnt_ids.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (resp_valid && resp_ready) rsp_got.push_back({resp_id, resp_data});
            if (resp_valid) resp_seen = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         output rec_t got, output bit timeout);
        int n;
        n = 0;
        a_drv[idx] = a;
        b_drv[idx] = b;
        req_valid[idx] = 1'b1;
        resp_ready = 1'b1;
        #1;
        while (!req_ready[idx] && n < 20) begin step(); n++; end
        step();
        req_valid[idx] = 1'b0;
        while (!resp_valid && n < 40) begin step(); n++; end
        got = {resp_id, resp_data};
        step();
        timeout = (n >= 40);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin a_drv[i] = '0; b_drv[i] = '0; end
        #1 rst_n = 1'b0;
        repeat (3) step();
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_vec++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
        n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (mult_en !== 1'b0) begin n_err++; $display("FAIL rst_mult_en: got %b want 0", mult_en); end
        n_vec++; if ({mult_a, mult_b} !== 32'h0) begin n_err++; $display("FAIL rst_mult_ops: got %h %h want 0 0", mult_a, mult_b); end
        rst_n = 1'b1;
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int n;
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        rec_t got, exp;
        gnt_ids.delete();
        gnt_cyc.delete();
        for (int i = 0; i < 4; i++) begin a_drv[i] = 16'(i + 1); b_drv[i] = 16'h0010; end
        req_valid = 4'hF;
        resp_ready = 1'b1;
        n = 0;
        while (gnt_ids.size() < 5 && n < 100) begin step(); n++; end
        req_valid = '0;
        while (busy && n < 120) begin step(); n++; end
        n_vec++; if (n >= 100) begin n_err++; $display("FAIL rr_timeout: grants %0d want 5", gnt_ids.size()); end
        for (int k = 0; k < 5 && k < gnt_ids.size(); k++) begin
            n_vec++;
            if (gnt_ids[k] !== exp_ids[k]) begin
                n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gnt_ids[k], exp_ids[k]);
            end
            if (k > 0) begin
                n_vec++;
                if (gnt_cyc[k] - gnt_cyc[k-1] !== 4) begin
                    n_err++; $display("FAIL rr_interval[%0d]: got %0d want 4", k, gnt_cyc[k] - gnt_cyc[k-1]);
                end
            end
        end
        n_vec++; if (rsp_got.size() !== 5) begin n_err++; $display("FAIL rr_resp_count: got %0d want 5", rsp_got.size()); end
        while (rsp_got.size() > 0) begin
            got = rsp_got.pop_front();
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL rr_unexpected: got id %0d data %h want none", got.id, got.data); end
            else begin
                exp = sb.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL rr_resp: got id %0d data %h want id %0d data %h", got.id, got.data, exp.id, exp.data); end
            end
            n_vec++;
            if (got.data !== 32'h10 * (32'(got.id) + 1)) begin n_err++; $display("FAIL rr_product: got %h want %h", got.data, 32'h10 * (32'(got.id) + 1)); end
        end
    endtask

    task automatic test_single();
        int lat, en_cnt;
        rec_t got, exp;
        resp_ready = 1'b0;
        a_drv[0] = 16'h1234;
        b_drv[0] = 16'h5678;
        req_valid = 4'b0001;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        n_vec++; if (mult_a !== 16'h1234 || mult_b !== 16'h5678) begin n_err++; $display("FAIL single_mult_ops: got %h %h want 1234 5678", mult_a, mult_b); end
        lat = 0;
        en_cnt = 0;
        while (!resp_valid && lat < 20) begin
            if (mult_en) en_cnt++;
            step();
            lat++;
        end
        if (mult_en) en_cnt++;
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", lat); end
        n_vec++; if (en_cnt !== 2) begin n_err++; $display("FAIL single_enable_cycles: got %0d want 2", en_cnt); end
        n_vec++; if (resp_data !== 32'h06260060) begin n_err++; $display("FAIL single_data: got %h want 06260060", resp_data); end
        n_vec++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", resp_id); end
        resp_ready = 1'b1;
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: busy %b want 0", busy); end
        while (rsp_got.size() > 0) begin
            got = rsp_got.pop_front();
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL single_unexpected: got id %0d want none", got.id); end
            else begin
                exp = sb.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL single_resp: got %0d/%h want %0d/%h", got.id, got.data, exp.id, exp.data); end
            end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] av[3] = '{16'hFFFF, 16'h0000, 16'h8000};
        logic [15:0] bv[3] = '{16'hFFFF, 16'hBEEF, 16'h0002};
        logic [31:0] pv[3] = '{32'hFFFE0001, 32'h00000000, 32'h00010000};
        rec_t got, exp;
        bit to;
        for (int k = 0; k < 3; k++) begin
            do_op(k + 1, av[k], bv[k], got, to);
            n_vec++; if (to) begin n_err++; $display("FAIL ext_timeout[%0d]: no response", k); end
            n_vec++;
            if (got.data !== pv[k] || got.id !== 2'(k + 1)) begin
                n_err++; $display("FAIL ext_product[%0d]: got %0d/%h want %0d/%h", k, got.id, got.data, k + 1, pv[k]);
            end
        end
        while (rsp_got.size() > 0) begin
            got = rsp_got.pop_front();
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL ext_unexpected: got id %0d want none", got.id); end
            else begin
                exp = sb.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL ext_resp: got %0d/%h want %0d/%h", got.id, got.data, exp.id, exp.data); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        rec_t snap, got, exp;
        resp_ready = 1'b0;
        a_drv[0] = 16'd3;  b_drv[0] = 16'd5;
        a_drv[2] = 16'd7;  b_drv[2] = 16'd9;
        req_valid = 4'b0001;
        #1;
        step();
        req_valid = 4'b0100;
        n = 0;
        while (!resp_valid && n < 20) begin step(); n++; end
        snap = {resp_id, resp_data};
        n_vec++; if (snap !== {2'd0, 32'd15}) begin n_err++; $display("FAIL bp_first: got %0d/%h want 0/0000000f", snap.id, snap.data); end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({resp_id, resp_data} !== snap || req_ready !== 4'b0 || busy !== 1'b1 || resp_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %0d/%h rdy %b busy %b vld %b want %0d/%h 0000 1 1",
                                  k, resp_id, resp_data, req_ready, busy, resp_valid, snap.id, snap.data);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_regrant: got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        n_vec++; if (rsp_got.size() !== 2) begin n_err++; $display("FAIL bp_resp_count: got %0d want 2", rsp_got.size()); end
        while (rsp_got.size() > 0) begin
            got = rsp_got.pop_front();
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL bp_unexpected: got id %0d want none", got.id); end
            else begin
                exp = sb.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL bp_resp: got %0d/%h want %0d/%h", got.id, got.data, exp.id, exp.data); end
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        int n;
        rec_t got, exp;
        a_drv[1] = 16'hABCD; b_drv[1] = 16'h1111;
        resp_ready = 1'b1;
        req_valid = 4'b0010;
        #1;
        step();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({resp_valid, busy, mult_en, req_ready} !== 7'b0 || resp_data !== 32'h0 || resp_id !== 2'd0
            || mult_a !== 16'h0 || mult_b !== 16'h0) begin
            n_err++; $display("FAIL mid_reset_outputs: vld %b busy %b en %b rdy %b data %h id %0d ops %h %h want all 0",
                              resp_valid, busy, mult_en, req_ready, resp_data, resp_id, mult_a, mult_b);
        end
        sb.delete();
        rsp_got.delete();
        repeat (2) step();
        rst_n = 1'b1;
        resp_seen = 1'b0;
        repeat (20) step();
        n_vec++; if (resp_seen !== 1'b0) begin n_err++; $display("FAIL mid_reset_ghost_resp: got response want none"); end
        for (int i = 0; i < 4; i++) begin a_drv[i] = 16'(16'h0100 + i); b_drv[i] = 16'h0003; end
        req_valid = 4'hF;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_reset_priority: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        n_vec++; if (rsp_got.size() !== 1) begin n_err++; $display("FAIL mid_reset_resp_count: got %0d want 1", rsp_got.size()); end
        while (rsp_got.size() > 0) begin
            got = rsp_got.pop_front();
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL mid_reset_unexpected: got id %0d want none", got.id); end
            else begin
                exp = sb.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL mid_reset_resp: got %0d/%h want %0d/%h", got.id, got.data, exp.id, exp.data); end
            end
        end
    endtask

    task automatic test_drop();
        int n, id1_hits;
        rec_t got, exp;
        resp_ready = 1'b0;
        a_drv[0] = 16'd2;    b_drv[0] = 16'd3;
        a_drv[1] = 16'h0011; b_drv[1] = 16'd2;
        a_drv[3] = 16'h0033; b_drv[3] = 16'd2;
        req_valid = 4'b0001;
        #1;
        step();
        req_valid = 4'b1010;
        n = 0;
        while (!resp_valid && n < 20) begin step(); n++; end
        repeat (2) step();
        req_valid[1] = 1'b0;
        resp_ready = 1'b1;
        step();
        n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL drop_grant: got %b want 1000", req_ready); end
        step();
        req_valid = '0;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        n_vec++; if (rsp_got.size() !== 2) begin n_err++; $display("FAIL drop_resp_count: got %0d want 2", rsp_got.size()); end
        id1_hits = 0;
        while (rsp_got.size() > 0) begin
            got = rsp_got.pop_front();
            if (got.id == 2'd1) id1_hits++;
            n_vec++;
            if (sb.size() == 0) begin n_err++; $display("FAIL drop_unexpected: got id %0d want none", got.id); end
            else begin
                exp = sb.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL drop_resp: got %0d/%h want %0d/%h", got.id, got.data, exp.id, exp.data); end
            end
        end
        n_vec++; if (id1_hits !== 0) begin n_err++; $display("FAIL drop_id1: got %0d responses want 0", id1_hits); end
    endtask

    initial begin
        cyc = 0;
        n_vec = 0;
        n_err = 0;
        resp_seen = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_extremes();
        test_backpressure();
        test_reset_mid_exec();
        test_drop();
        n_vec++;
        if (sb.size() !== 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
